// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the EX-stage multiply/divide unit.
package ex_muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        OpMultu = 2'b00,
        OpMult  = 2'b01,
        OpDivu  = 2'b10,
        OpDiv   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
interface ex_muldiv_ctrl_if #(
    parameter int unsigned LEN   = 32,
    parameter int unsigned NB_OP = 2
);
    logic             i_valid;
    logic [NB_OP-1:0] i_op;
    logic [LEN-1:0]   i_dato_a;
    logic [LEN-1:0]   i_dato_b;
    logic             i_flush;
    logic             o_stall;
    logic             o_busy;
    logic             o_done;
    logic             o_div_by_zero;
    logic [LEN-1:0]   o_hi;
    logic [LEN-1:0]   o_lo;

    modport master (
        output i_valid, i_op, i_dato_a, i_dato_b, i_flush,
        input  o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

    modport slave (
        input  i_valid, i_op, i_dato_a, i_dato_b, i_flush,
        output o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_ctrl_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
module ex_muldiv_ctrl_step #(
    parameter int unsigned LEN = 32
) (
    input  logic             is_div_i,
    input  logic [2*LEN-1:0] acc_i,    // mul: {hi, lo}; div: {rem, quo}
    input  logic [LEN-1:0]   opnd_i,   // mul: multiplicand; div: divisor
    output logic [2*LEN-1:0] acc_o
);
    logic [LEN:0]   sum;
    logic [LEN:0]   rem_sh;
    logic [LEN-1:0] rem_sub;

    always_comb begin
        sum     = {1'b0, acc_i[2*LEN-1:LEN]};
        if (acc_i[0]) begin
            sum = sum + {1'b0, opnd_i};
        end
        // Remainder needs LEN+1 bits after the shift before the compare.
        rem_sh  = {acc_i[2*LEN-1:LEN], acc_i[LEN-1]};
        rem_sub = rem_sh[LEN-1:0] - opnd_i;

        if (!is_div_i) begin
            acc_o = {sum, acc_i[LEN-1:1]};
        end else if (rem_sh >= {1'b0, opnd_i}) begin
            acc_o = {rem_sub, acc_i[LEN-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[LEN-1:0], acc_i[LEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the front end while busy.
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned LEN    = 32,
    parameter int unsigned NB_OP  = 2,
    parameter int unsigned NB_CNT = 5
) (
    input logic               i_clk,
    input logic               i_rst,
    ex_muldiv_ctrl_if.slave   bus
);
    state_e             state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic [2*LEN-1:0]   acc_q, acc_d, acc_step;
    logic [LEN-1:0]     opnd_q, opnd_d;
    logic [LEN-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic               div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;

    logic               accept, op_div, sa, sb;
    logic [LEN-1:0]     a_abs, b_abs;
    logic [2*LEN-1:0]   prod;
    logic [LEN-1:0]     quo, rem;

    ex_muldiv_ctrl_step #(.LEN(LEN)) u_step (
        .is_div_i (div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        accept = bus.i_valid & ~bus.i_flush;
        op_div = op_is_div(bus.i_op);
        sa     = op_is_signed(bus.i_op) & bus.i_dato_a[LEN-1];
        sb     = op_is_signed(bus.i_op) & bus.i_dato_b[LEN-1];
        a_abs  = sa ? -bus.i_dato_a : bus.i_dato_a;
        b_abs  = sb ? -bus.i_dato_b : bus.i_dato_b;
        // Product sign shares qneg with the quotient sign; rneg only matters for divide.
        prod   = qneg_q ? -acc_q : acc_q;
        quo    = qneg_q ? -acc_q[LEN-1:0] : acc_q[LEN-1:0];
        rem    = rneg_q ? -acc_q[2*LEN-1:LEN] : acc_q[2*LEN-1:LEN];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    div_d  = op_div;
                    qneg_d = sa ^ sb;
                    rneg_d = sa;
                    cnt_d  = '0;
                    if (op_div && (bus.i_dato_b == '0)) begin
                        state_d = StDone;
                        hi_d    = bus.i_dato_a;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StCalc;
                        acc_d   = {{LEN{1'b0}}, (op_div ? a_abs : b_abs)};
                        opnd_d  = op_div ? b_abs : a_abs;
                    end
                end
            end
            StCalc: begin
                if (bus.i_flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + NB_CNT'(1);
                    if (cnt_q == NB_CNT'(LEN - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                if (bus.i_flush) begin
                    state_d = StIdle;
                end else begin
                    state_d = StDone;
                    if (div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*LEN-1:LEN];
                        lo_d = prod[LEN-1:0];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
        end
    end

    // Stall drops in DONE so the instruction leaves EX exactly once.
    assign bus.o_stall       = ((state_q == StIdle) & accept) | (state_q == StCalc)
                               | (state_q == StFix);
    assign bus.o_busy        = (state_q != StIdle);
    assign bus.o_done        = (state_q == StDone);
    assign bus.o_div_by_zero = (state_q == StDone) & dbz_q;
    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: directed ops push expectations, a monitor checks o_done.
module tb_ex_muldiv_ctrl;
    import ex_muldiv_ctrl_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];

    ex_muldiv_ctrl_if #(.LEN(32), .NB_OP(2)) bus ();

    ex_muldiv_ctrl #(.LEN(32), .NB_OP(2), .NB_CNT(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every o_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_div_by_zero && !bus.o_done) check("dbz_without_done", 32'd1, 32'd0);
            if (bus.o_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("hi", bus.o_hi, e.hi);
                    check("lo", bus.o_lo, e.lo);
                    check("div_by_zero", {31'd0, bus.o_div_by_zero}, {31'd0, e.dbz});
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Called at #1 after a posedge; returns at #1 after the posedge following DONE.
    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic dbz);
        int lat;
        int stalls;
        bit seen;
        lat    = dbz ? 1 : 34;
        stalls = 0;
        seen   = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_op     = op;
        bus.i_dato_a = a;
        bus.i_dato_b = b;
        sb_q.push_back('{hi: ehi, lo: elo, dbz: dbz, cyc: cyc + lat});
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.o_done) begin
                seen = 1'b1;
                check("stall_in_done", {31'd0, bus.o_stall}, 32'd0);
                break;
            end
            if (bus.o_stall) stalls++;
            @(posedge clk);
            #1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        check("stall_cycles", stalls, lat);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    // Start a DIVU, then at cycle 10 after accept kill it with flush or reset.
    task automatic abort_op(input bit use_rst, input logic [31:0] ehi, input logic [31:0] elo);
        bus.i_valid  = 1'b1;
        bus.i_op     = OpDivu;
        bus.i_dato_a = 32'd100;
        bus.i_dato_b = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        if (use_rst) rst = 1'b1;
        else bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_flush = 1'b0;
        @(negedge clk);
        check(use_rst ? "rst_busy" : "flush_busy", {31'd0, bus.o_busy}, 32'd0);
        check(use_rst ? "rst_stall" : "flush_stall", {31'd0, bus.o_stall}, 32'd0);
        check(use_rst ? "rst_hi" : "flush_hi", bus.o_hi, ehi);
        check(use_rst ? "rst_lo" : "flush_lo", bus.o_lo, elo);
        // Any stray o_done in this window is flagged by the monitor.
        for (int i = 0; i < 40; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_op     = OpMultu;
        bus.i_dato_a = '0;
        bus.i_dato_b = '0;
        bus.i_flush  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_hi", bus.o_hi, 32'd0);
        check("reset_lo", bus.o_lo, 32'd0);
        check("reset_busy", {31'd0, bus.o_busy}, 32'd0);
        check("reset_stall", {31'd0, bus.o_stall}, 32'd0);
        check("reset_done", {31'd0, bus.o_done}, 32'd0);
        @(posedge clk);
        #1;

        run_op(OpMultu, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0);
        run_op(OpMult,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op(OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0);
        run_op(OpMult,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'h0,        32'd12,       1'b0);
        run_op(OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(OpDiv,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
        run_op(OpDivu,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_op(OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0);
        run_op(OpDivu,  32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF, 1'b1);

        // Flush has priority over valid while idle.
        bus.i_valid = 1'b1;
        bus.i_flush = 1'b1;
        @(negedge clk);
        check("idle_flush_stall", {31'd0, bus.o_stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", {31'd0, bus.o_busy}, 32'd0);
        @(posedge clk);
        #1;

        run_op(OpMultu, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);
        abort_op(1'b0, 32'd0, 32'd9);
        abort_op(1'b1, 32'd0, 32'd0);

        // Back-to-back: second op accepted in the cycle right after DONE.
        run_op(OpMultu, 32'd11,       32'd13,       32'd0,        32'd143,      1'b0);
        run_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
